// File: rtl/eth_pll_pkg.sv
// Shared types and helpers for the Ethernet PLL lock supervisor.
package eth_pll_pkg;

    typedef enum logic [2:0] {
        PS_RESET,
        PS_WAIT_LOCK,
        PS_STABLE,
        PS_READY,
        PS_FAULT
    } pll_state_e;

    localparam int LOSS_CNT_W = 8;

    // One extra bit over the largest limit keeps every terminal compare in range.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/eth_pll_chan_fsm.sv
// One supervised PLL channel: lock synchroniser, reset/lock FSM, retry count.
// Optional lock-loss counter built when ETH_PLL_LOSS_CNT_EN is defined.
module eth_pll_chan_fsm
    import eth_pll_pkg::*;
#(
    parameter int SYNC_STAGES         = 2,
    parameter int RESET_PULSE_CYCLES  = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 3
) (
    input  logic                  refclk,
    input  logic                  rst_n,
    input  logic                  pll_locked_i,
    input  logic                  force_relock_i,
    input  logic                  clear_fault_i,
    output logic                  pll_rst_o,
    output logic                  chan_ready_o,
    output logic                  chan_fault_o,
    output logic [LOSS_CNT_W-1:0] loss_cnt_o
);

    localparam int CNT_W = cnt_width(RESET_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
    localparam int RET_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RESET_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STB_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RET_W-1:0] RET_LIMIT = RET_W'(MAX_RETRIES);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    pll_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [RET_W-1:0]       retries_q, retries_d;
    logic                   pll_rst_q, pll_rst_d;
    logic                   ready_q, ready_d;
    logic                   fault_q, fault_d;
    logic                   lk;
    logic                   fail;

    assign lk = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], pll_locked_i};
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        retries_d = retries_q;
        fail      = 1'b0;

        unique case (state_q)
            PS_RESET: begin
                if (cnt_q == RST_LAST) begin
                    state_d = PS_WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            PS_WAIT_LOCK: begin
                if (lk) begin
                    state_d = PS_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TO_LAST) begin
                    fail = 1'b1;
                end
            end
            PS_STABLE: begin
                if (!lk) begin
                    fail = 1'b1;
                end else if (cnt_q == STB_LAST) begin
                    state_d = PS_READY;
                    cnt_d   = '0;
                end
            end
            PS_READY: begin
                cnt_d = cnt_q;
                if (!lk) fail = 1'b1;
            end
            PS_FAULT: begin
                cnt_d = cnt_q;
                if (clear_fault_i) begin
                    state_d   = PS_RESET;
                    cnt_d     = '0;
                    retries_d = '0;
                end
            end
            default: begin
                state_d = PS_RESET;
                cnt_d   = '0;
            end
        endcase

        if (fail) begin
            cnt_d = '0;
            if (retries_q == RET_LIMIT) begin
                state_d = PS_FAULT;
            end else begin
                state_d   = PS_RESET;
                retries_d = retries_q + RET_W'(1);
            end
        end

        // A forced relock overrides a same-cycle failure and charges no retry.
        if (force_relock_i && state_q != PS_FAULT) begin
            state_d   = PS_RESET;
            cnt_d     = '0;
            retries_d = retries_q;
        end

        pll_rst_d = (state_d == PS_RESET) || (state_d == PS_FAULT);
        ready_d   = (state_d == PS_READY);
        fault_d   = (state_d == PS_FAULT);
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            state_q   <= PS_RESET;
            cnt_q     <= '0;
            retries_q <= '0;
            pll_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retries_q <= retries_d;
            pll_rst_q <= pll_rst_d;
            ready_q   <= ready_d;
            fault_q   <= fault_d;
        end
    end

    assign pll_rst_o    = pll_rst_q;
    assign chan_ready_o = ready_q;
    assign chan_fault_o = fault_q;

`ifdef ETH_PLL_LOSS_CNT_EN
    logic [LOSS_CNT_W-1:0] loss_q, loss_d;
    logic                  loss_evt;
    logic                  loss_clr;

    // Only a genuine READY failure counts; a forced relock wins that cycle.
    assign loss_evt = (state_q == PS_READY) && !lk && !force_relock_i;
    assign loss_clr = (state_q == PS_FAULT) && clear_fault_i;

    always_comb begin
        loss_d = loss_q;
        if (loss_clr) begin
            loss_d = '0;
        end else if (loss_evt && (loss_q != '1)) begin
            loss_d = loss_q + LOSS_CNT_W'(1);
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) loss_q <= '0;
        else        loss_q <= loss_d;
    end

    assign loss_cnt_o = loss_q;
`else
    assign loss_cnt_o = '0;
`endif

endmodule

// File: rtl/eth_pll_lock_mgr.sv
// Multi-channel PLL reset/lock supervisor; one eth_pll_chan_fsm per PLL.
// Define ETH_PLL_LOSS_CNT_EN to build the per-channel lock-loss counters.
module eth_pll_lock_mgr
    import eth_pll_pkg::*;
#(
    parameter int NUM_PLLS            = 4,
    parameter int SYNC_STAGES         = 2,
    parameter int RESET_PULSE_CYCLES  = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 3
) (
    input  logic                           refclk,
    input  logic                           rst_n,
    input  logic [NUM_PLLS-1:0]            pll_locked_i,
    input  logic [NUM_PLLS-1:0]            force_relock_i,
    input  logic [NUM_PLLS-1:0]            clear_fault_i,
    output logic [NUM_PLLS-1:0]            pll_rst_o,
    output logic [NUM_PLLS-1:0]            chan_ready_o,
    output logic [NUM_PLLS-1:0]            chan_fault_o,
    output logic                           all_locked_o,
    output logic [LOSS_CNT_W*NUM_PLLS-1:0] loss_cnt_o
);

    logic all_locked_q, all_locked_d;

    for (genvar i = 0; i < NUM_PLLS; i++) begin : g_chan
        eth_pll_chan_fsm #(
            .SYNC_STAGES        (SYNC_STAGES),
            .RESET_PULSE_CYCLES (RESET_PULSE_CYCLES),
            .LOCK_TIMEOUT_CYCLES(LOCK_TIMEOUT_CYCLES),
            .LOCK_STABLE_CYCLES (LOCK_STABLE_CYCLES),
            .MAX_RETRIES        (MAX_RETRIES)
        ) u_chan (
            .refclk        (refclk),
            .rst_n         (rst_n),
            .pll_locked_i  (pll_locked_i[i]),
            .force_relock_i(force_relock_i[i]),
            .clear_fault_i (clear_fault_i[i]),
            .pll_rst_o     (pll_rst_o[i]),
            .chan_ready_o  (chan_ready_o[i]),
            .chan_fault_o  (chan_fault_o[i]),
            .loss_cnt_o    (loss_cnt_o[LOSS_CNT_W*i +: LOSS_CNT_W])
        );
    end

    always_comb begin
        all_locked_d = &chan_ready_o;
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) all_locked_q <= 1'b0;
        else        all_locked_q <= all_locked_d;
    end

    assign all_locked_o = all_locked_q;

endmodule

// File: tb/tb_eth_pll_lock_mgr.sv
// Directed bench for eth_pll_lock_mgr with short limits (pulse 4, timeout 20, stable 8, retries 2).
module tb_eth_pll_lock_mgr;

    logic        refclk;
    logic        rst_n;
    logic [3:0]  lock;
    logic [3:0]  force_rl;
    logic [3:0]  clr;
    logic [3:0]  pll_rst;
    logic [3:0]  ready;
    logic [3:0]  fault;
    logic        all_locked;
    logic [31:0] loss;

    int checks = 0;
    int errors = 0;

`ifdef ETH_PLL_LOSS_CNT_EN
    localparam logic [31:0] LOSS_AFTER_DROP = 32'h1;
`else
    localparam logic [31:0] LOSS_AFTER_DROP = 32'h0;
`endif

    eth_pll_lock_mgr #(
        .NUM_PLLS           (4),
        .SYNC_STAGES        (2),
        .RESET_PULSE_CYCLES (4),
        .LOCK_TIMEOUT_CYCLES(20),
        .LOCK_STABLE_CYCLES (8),
        .MAX_RETRIES        (2)
    ) dut (
        .refclk        (refclk),
        .rst_n         (rst_n),
        .pll_locked_i  (lock),
        .force_relock_i(force_rl),
        .clear_fault_i (clr),
        .pll_rst_o     (pll_rst),
        .chan_ready_o  (ready),
        .chan_fault_o  (fault),
        .all_locked_o  (all_locked),
        .loss_cnt_o    (loss)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge refclk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rst"},   {28'd0, pll_rst}, 32'hF);
        chk({tag, "_rdy"},   {28'd0, ready},   32'h0);
        chk({tag, "_flt"},   {28'd0, fault},   32'h0);
        chk({tag, "_all"},   {31'd0, all_locked}, 32'h0);
        chk({tag, "_loss"},  loss,             32'h0);
    endtask

    initial begin
        logic [3:0] er, ey, ef;
        rst_n    = 1'b0;
        lock     = 4'h0;
        force_rl = 4'h0;
        clr      = 4'h0;

        // Phase A: bring-up, single-cycle lock drop, force vs. loss, STABLE glitch
        step(3);
        chk_reset_vals("a_reset");
        rst_n = 1'b1;
        step(3);                                   // edge 3
        chk("a_rst_held", {28'd0, pll_rst}, 32'hF);
        step(1);                                   // edge 4
        chk("a_rst_rel", {28'd0, pll_rst}, 32'h0);
        step(1);                                   // edge 5
        lock = 4'hF;
        step(10);                                  // edge 15
        chk("a_rdy_early", {28'd0, ready}, 32'h0);
        step(1);                                   // edge 16
        chk("a_rdy", {28'd0, ready}, 32'hF);
        chk("a_all_lag", {31'd0, all_locked}, 32'h0);
        step(1);                                   // edge 17
        chk("a_all", {31'd0, all_locked}, 32'h1);

        lock = 4'hE;
        step(1);                                   // edge 18
        lock = 4'hF;
        chk("a_drop_e18", {28'd0, ready}, 32'hF);
        step(1);                                   // edge 19
        chk("a_drop_e19", {28'd0, ready}, 32'hF);
        step(1);                                   // edge 20
        chk("a_drop_rdy", {28'd0, ready}, 32'hE);
        chk("a_drop_rst", {28'd0, pll_rst}, 32'h1);
        chk("a_drop_loss", loss, LOSS_AFTER_DROP);
        chk("a_drop_retry", {30'd0, dut.g_chan[0].u_chan.retries_q}, 32'd1);
        step(1);                                   // edge 21
        chk("a_drop_all", {31'd0, all_locked}, 32'h0);
        step(2);                                   // edge 23
        chk("a_pulse_hi", {28'd0, pll_rst}, 32'h1);
        step(1);                                   // edge 24
        chk("a_pulse_lo", {28'd0, pll_rst}, 32'h0);
        step(8);                                   // edge 32
        chk("a_relock_early", {28'd0, ready}, 32'hE);
        step(1);                                   // edge 33
        chk("a_relock", {28'd0, ready}, 32'hF);

        lock = 4'hE;
        step(2);                                   // edge 35
        chk("a_force_pre", {28'd0, ready}, 32'hF);
        force_rl = 4'h1;
        step(1);                                   // edge 36
        force_rl = 4'h0;
        lock     = 4'hF;
        chk("a_force_rdy", {28'd0, ready}, 32'hE);
        chk("a_force_rst", {28'd0, pll_rst}, 32'h1);
        chk("a_force_retry", {30'd0, dut.g_chan[0].u_chan.retries_q}, 32'd1);
        step(4);                                   // edge 40
        chk("a_force_wait", {28'd0, pll_rst}, 32'h0);
        step(6);                                   // edge 46
        lock = 4'hE;
        step(1);                                   // edge 47
        lock = 4'hF;
        step(1);                                   // edge 48
        chk("a_glitch_pre", {28'd0, ready}, 32'hE);
        step(1);                                   // edge 49
        chk("a_glitch_rdy", {28'd0, ready}, 32'hE);
        chk("a_glitch_rst", {28'd0, pll_rst}, 32'h1);
        chk("a_glitch_retry", {30'd0, dut.g_chan[0].u_chan.retries_q}, 32'd2);

        // Phase B: channel 2 never locks and faults; others stay ready
        rst_n = 1'b0;
        lock  = 4'b1011;
        step(1);
        chk_reset_vals("b_reset");
        chk("b_retry_clr", {30'd0, dut.g_chan[0].u_chan.retries_q}, 32'd0);
        rst_n = 1'b1;
        for (int k = 1; k <= 80; k++) begin
            step(1);
            er    = (k <= 3) ? 4'hF : 4'h0;
            er[2] = (k <= 3) || (k >= 24 && k <= 27) || (k >= 48 && k <= 51) || (k >= 72);
            ey    = (k >= 13) ? 4'b1011 : 4'b0000;
            ef    = (k >= 72) ? 4'b0100 : 4'b0000;
            chk($sformatf("b_rst_%0d", k), {28'd0, pll_rst}, {28'd0, er});
            chk($sformatf("b_rdy_%0d", k), {28'd0, ready},   {28'd0, ey});
            chk($sformatf("b_flt_%0d", k), {28'd0, fault},   {28'd0, ef});
            chk($sformatf("b_all_%0d", k), {31'd0, all_locked}, 32'h0);
        end

        force_rl = 4'b0100;
        step(1);
        force_rl = 4'h0;
        chk("b_force_in_fault", {28'd0, fault}, 32'h4);
        chk("b_force_in_fault_rst", {28'd0, pll_rst}, 32'h4);

        clr  = 4'b0101;
        lock = 4'hF;
        step(1);                                   // edge C
        clr = 4'h0;
        chk("b_clr_flt", {28'd0, fault}, 32'h0);
        chk("b_clr_rdy", {28'd0, ready}, 32'hB);
        chk("b_clr_rst", {28'd0, pll_rst}, 32'h4);
        chk("b_clr_retry", {30'd0, dut.g_chan[2].u_chan.retries_q}, 32'd0);
        step(12);                                  // edge C+12
        chk("b_clr_early", {28'd0, ready}, 32'hB);
        step(1);                                   // edge C+13
        chk("b_clr_ready", {28'd0, ready}, 32'hF);
        step(1);
        chk("b_clr_all", {31'd0, all_locked}, 32'h1);

        // Phase C: force all channels, then async reset during WAIT_LOCK
        force_rl = 4'hF;
        step(1);
        force_rl = 4'h0;
        lock     = 4'h0;
        chk("c_force_rdy", {28'd0, ready}, 32'h0);
        chk("c_force_rst", {28'd0, pll_rst}, 32'hF);
        step(4);
        chk("c_wait", {28'd0, pll_rst}, 32'h0);
        step(2);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("c_async");
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
